// File: rtl/idft_cordic_pkg.sv
// Shared constants, state encoding and the CORDIC arctan table for the 16-point IDFT.
package idft_cordic_pkg;

  localparam int IDFT_W    = 16;
  localparam int IDFT_ITER = 11;
  localparam int ACC_W     = 21;
  localparam int GAIN      = 622;
  localparam int PI8_Q     = 402;

  typedef enum logic [1:0] {S_LOAD, S_ROT, S_SCALE, S_EMIT} state_e;

  // atan(2^-i) in Q5.10 radians; deeper iterations contribute nothing
  function automatic int atan_q(input int i);
    case (i)
      0:       return 804;
      1:       return 475;
      2:       return 251;
      3:       return 127;
      4:       return 64;
      5:       return 32;
      6:       return 16;
      7:       return 8;
      8:       return 4;
      9:       return 2;
      10:      return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/idft_cordic_cordic_rot.sv
// Rotates (re,im) by m*pi/8: exact quadrant turn on start, then ITER CORDIC micro-rotations.
module cordic_rot #(
  parameter int W    = 16,
  parameter int ITER = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] re_in,
  input  logic signed [W-1:0] im_in,
  input  logic [3:0]          m,
  output logic                busy,
  output logic                done,
  output logic signed [W+1:0] re_out
);
  import idft_cordic_pkg::*;

  localparam int DW = W + 2;
  localparam int IW = $clog2(ITER + 1);

  logic              act_q, act_d;
  logic [IW-1:0]     it_q, it_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [DW-1:0] pre_x, pre_y, re_x, im_x, z_start;
  logic signed [DW-1:0] x_n, y_n, z_n, x_sh, y_sh, atan_v;

  always_comb begin
    re_x    = DW'(re_in);
    im_x    = DW'(im_in);
    pre_x   = re_x;
    pre_y   = im_x;
    case (m[3:2])
      2'd1:    begin pre_x = -im_x; pre_y = re_x;  end
      2'd2:    begin pre_x = -re_x; pre_y = -im_x; end
      2'd3:    begin pre_x = im_x;  pre_y = -re_x; end
      default: begin pre_x = re_x;  pre_y = im_x;  end
    endcase
    z_start = DW'(int'(m[1:0]) * PI8_Q);

    x_sh   = x_q >>> it_q;
    y_sh   = y_q >>> it_q;
    atan_v = DW'(atan_q(int'(it_q)));
    if (!z_q[DW-1]) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_v;
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_v;
    end
  end

  assign busy   = act_q;
  assign done   = act_q && (it_q == IW'(ITER - 1));
  assign re_out = x_n;

  always_comb begin
    act_d = act_q;
    it_d  = it_q;
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    if (act_q) begin
      x_d  = x_n;
      y_d  = y_n;
      z_d  = z_n;
      it_d = it_q + 1'b1;
      if (done) act_d = 1'b0;
    end else if (start) begin
      x_d   = pre_x;
      y_d   = pre_y;
      z_d   = z_start;
      it_d  = '0;
      act_d = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      it_q  <= '0;
    end else begin
      act_q <= act_d;
      it_q  <= it_d;
    end
  end

  always_ff @(negedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
    z_q <= z_d;
  end

endmodule

// File: rtl/idft_cordic.sv
// 16-point inverse DFT: loads 16 bins, accumulates one CORDIC-rotated term per 12 cycles,
// scales by the CORDIC gain and 1/16, then presents each time sample with a valid/ready handshake.
module idft_cordic #(
  parameter int W    = 16,
  parameter int ITER = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic [3:0]          out_idx,
  output logic                busy
);
  import idft_cordic_pkg::*;

  localparam int PW     = 32;
  localparam int SAT_HI = (1 << (W - 1)) - 1;
  localparam int SAT_LO = -(1 << (W - 1));

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > SAT_HI)      return W'(SAT_HI);
    else if (v < SAT_LO) return W'(SAT_LO);
    else                 return W'(v);
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              n_q, n_d, k_q, k_d, cnt_q, cnt_d;
  logic                    ph_q, ph_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [W-1:0]     out_data_q, out_data_d;
  logic signed [W-1:0]     bin_re_q [16];
  logic signed [W-1:0]     bin_im_q [16];

  logic                    ld_fire, cr_start, cr_busy, cr_done;
  logic [3:0]              tw_m;
  logic signed [W+1:0]     cr_re;

  assign ld_fire   = (state_q == S_LOAD) && in_valid;
  assign tw_m      = k_q * n_q;
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = out_data_q;
  assign out_idx   = n_q;

  cordic_rot #(.W(W), .ITER(ITER)) u_rot (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (cr_start),
    .re_in  (bin_re_q[k_q]),
    .im_in  (bin_im_q[k_q]),
    .m      (tw_m),
    .busy   (cr_busy),
    .done   (cr_done),
    .re_out (cr_re)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    out_data_d = out_data_q;
    cr_start   = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 4'd15) begin
            state_d = S_ROT;
            n_d     = '0;
            k_d     = '0;
            acc_d   = '0;
          end
        end
      end
      S_ROT: begin
        // a new term starts the cycle after the previous one retires, so no gaps between terms
        cr_start = !cr_busy;
        if (cr_done) begin
          acc_d = acc_q + ACC_W'(cr_re);
          k_d   = k_q + 1'b1;
          if (k_q == 4'd15) begin
            state_d = S_SCALE;
            ph_d    = 1'b0;
          end
        end
      end
      S_SCALE: begin
        if (!ph_q) begin
          prod_d = PW'(acc_q) * PW'(GAIN);
          ph_d   = 1'b1;
        end else begin
          out_data_d = sat_w(prod_q >>> 14);
          ph_d       = 1'b0;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          n_d = n_q + 1'b1;
          if (n_q == 4'd15) begin
            state_d = S_LOAD;
          end else begin
            k_d     = '0;
            acc_d   = '0;
            state_d = S_ROT;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      n_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(negedge clk) begin
    prod_q <= prod_d;
    if (ld_fire) begin
      bin_re_q[cnt_q] <= in_re;
      bin_im_q[cnt_q] <= in_im;
    end
  end

endmodule

// File: tb/tb_idft_cordic.sv
// Directed bench for idft_cordic: impulse bins against hand-computed cos/sin samples,
// latency, back-pressure, mid-run reset and gapped loading.
module tb_idft_cordic;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_data;
  logic [3:0]          out_idx;
  logic                busy;

  int n_vec = 0;
  int n_bad = 0;
  int bin_re [16];
  int bin_im [16];
  int ref_a  [16];

  // round(cos(2*pi*n/16)*1024) and round(-sin(2*pi*n/16)*1024)
  int cos_t [16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                     -1024, -946, -724, -392, 0, 392, 724, 946};
  int nsin_t [16] = '{0, -392, -724, -946, -1024, -946, -724, -392,
                      0, 392, 724, 946, 1024, 946, 724, 392};

  idft_cordic #(.W(W), .ITER(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got < exp - tol || got > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  task automatic set_bins(input int re_k, input int re_v, input int im_k, input int im_v);
    for (int i = 0; i < 16; i++) begin
      bin_re[i] = 0;
      bin_im[i] = 0;
    end
    if (re_k >= 0) bin_re[re_k] = re_v;
    if (im_k >= 0) bin_im[im_k] = im_v;
  endtask

  task automatic load_bins(input bit gappy);
    int  k   = 0;
    int  cyc = 0;
    bit  v;
    bit  rdy;
    while (k < 16 && cyc < 100) begin
      v        = gappy ? ((cyc % 2) == 0) : 1'b1;
      in_valid = v;
      in_re    = v ? W'(bin_re[k]) : 16'sh1234;
      in_im    = v ? W'(bin_im[k]) : -16'sd100;
      rdy      = in_ready;
      @(posedge clk);
      if (v && rdy) k++;
      cyc++;
    end
    in_valid = 1'b0;
    check("beats", k, 16, 0);
    check("busy_after_load", busy, 1, 0);
    check("in_ready_after_load", in_ready, 0, 0);
  endtask

  task automatic take(input int n, input bit noise, input int stall, output int data);
    int cnt = 0;
    while (!out_valid && cnt < 400) begin
      if (noise) begin
        in_valid = ~in_valid;
        in_re    = 16'sh1234;
        in_im    = -16'sd100;
      end
      @(posedge clk);
      cnt++;
    end
    check($sformatf("lat_n%0d", n), cnt, 194, 0);
    data = out_data;
    check($sformatf("idx_n%0d", n), out_idx, n, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      check("stall_data", out_data, data, 0);
      check("stall_idx", out_idx, n, 0);
      check("stall_vld", out_valid, 1, 0);
      check("stall_rdy", in_ready, 0, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    out_ready = 1'b0;
    check("vld_after_xfer", out_valid, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},  out_valid, 0, 0);
    check({tag, "_data"}, out_data, 0, 0);
    check({tag, "_idx"},  out_idx, 0, 0);
    check({tag, "_busy"}, busy, 0, 0);
    check({tag, "_rdy"},  in_ready, 1, 0);
  endtask

  initial begin
    int d;
    int seen;

    repeat (3) @(posedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    @(posedge clk);

    // DC: X[0] = 16.0 gives 1.0 at every n
    set_bins(0, 16384, -1, 0);
    load_bins(1'b0);
    for (int n = 0; n < 16; n++) begin
      take(n, 1'b0, 0, d);
      ref_a[n] = d;
      check($sformatf("dc_n%0d", n), d, 1024, 4);
    end

    // X[1] = 16.0 gives a cosine; stall the consumer at n=3
    set_bins(1, 16384, -1, 0);
    load_bins(1'b0);
    for (int n = 0; n < 16; n++) begin
      take(n, 1'b0, (n == 3) ? 50 : 0, d);
      check($sformatf("cos_n%0d", n), d, cos_t[n], 4);
    end

    // Y[1] = 16.0 gives a negated sine
    set_bins(-1, 0, 1, 16384);
    load_bins(1'b0);
    for (int n = 0; n < 16; n++) begin
      take(n, 1'b0, 0, d);
      check($sformatf("sin_n%0d", n), d, nsin_t[n], 4);
    end

    // reset during term n=5, k=7
    set_bins(0, 16384, -1, 0);
    load_bins(1'b0);
    for (int n = 0; n < 5; n++) begin
      take(n, 1'b0, 0, d);
      check($sformatf("pre_rst_n%0d", n), d, ref_a[n], 0);
    end
    repeat (90) @(posedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    check_reset_outputs("rst_rel");
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk);
      if (out_valid) seen++;
    end
    check("no_out_after_rst", seen, 0, 0);
    load_bins(1'b0);
    for (int n = 0; n < 16; n++) begin
      take(n, 1'b0, 0, d);
      check($sformatf("post_rst_n%0d", n), d, ref_a[n], 0);
    end

    // gapped load plus in_valid noise while busy must match the gapless run exactly
    load_bins(1'b1);
    for (int n = 0; n < 16; n++) begin
      take(n, 1'b1, 0, d);
      check($sformatf("gap_n%0d", n), d, ref_a[n], 0);
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
